// File: rtl/alu_arbiter.sv
// alu_arbiter: two-requester round-robin front end for a single shared
// combinational ALU, with a one-entry response register.
//
// Ports
//   clk, rst_n                 clock, asynchronous active-low reset
//   req_valid[1:0]             pending request per requester
//   req_ready[1:0]             one-hot grant, high only in the grant cycle
//   req_op0/req_op1[31:0]      operands, {r1[15:0], r0[15:0]}
//   req_ALU_op[5:0]            opcodes, {r1[2:0], r0[2:0]}
//   req_shamt[7:0]             shift/rotate amounts, {r1[3:0], r0[3:0]}
//   req_X[1:0]                 per-requester X (SR arithmetic / ROT right)
//   op0, op1, ALU_op, shamt, X drive the external ALU
//   result, N, Z, V            ALU result and flags
//   resp_valid / resp_ready    response handshake
//   resp_id, resp_result, resp_N, resp_Z, resp_V   registered response
//
// A ROT with shamt >= 2 (ROT_MULTI=1) is run as shamt single-step passes
// through the ALU, feeding each pass's result back as the next operand.

module alu_arbiter #(
  parameter int ROT_MULTI = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [1:0]  req_valid,
  output logic [1:0]  req_ready,
  input  logic [31:0] req_op0,
  input  logic [31:0] req_op1,
  input  logic [5:0]  req_ALU_op,
  input  logic [7:0]  req_shamt,
  input  logic [1:0]  req_X,
  output logic [15:0] op0,
  output logic [15:0] op1,
  output logic [2:0]  ALU_op,
  output logic [3:0]  shamt,
  output logic        X,
  input  logic [15:0] result,
  input  logic        N,
  input  logic        Z,
  input  logic        V,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic        resp_id,
  output logic [15:0] resp_result,
  output logic        resp_N,
  output logic        resp_Z,
  output logic        resp_V
);

  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_ROT = 3'b111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ITER = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t      state;
  state_t      state_next;

  logic        last_grant;
  logic        armed;
  logic [15:0] acc;
  logic [3:0]  cnt;
  logic        x_lat;

  logic        can_grant;
  logic        grant_en;
  logic        gnt_id;
  logic [15:0] sel_op0;
  logic [15:0] sel_op1;
  logic [2:0]  sel_op;
  logic [3:0]  sel_shamt;
  logic        sel_x;
  logic        sel_rot;
  logic        start_iter;
  logic        bypass;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Arbitration, ALU drive and next state. A grant is possible from IDLE,
  // or from RESP when the held response is consumed in the same cycle.
  // armed blocks the first cycle after reset release.
  always_comb begin
    state_next = state;
    req_ready  = 2'b00;
    op0        = 16'h0000;
    op1        = 16'h0000;
    ALU_op     = OP_AND;
    shamt      = 4'h0;
    X          = 1'b0;

    can_grant  = armed && ((state == IDLE) || ((state == RESP) && resp_ready));
    grant_en   = can_grant && (req_valid != 2'b00);
    // On a tie the requester that did not win last time goes next.
    gnt_id     = (req_valid == 2'b11) ? ~last_grant : req_valid[1];

    sel_op0    = gnt_id ? req_op0[31:16]   : req_op0[15:0];
    sel_op1    = gnt_id ? req_op1[31:16]   : req_op1[15:0];
    sel_op     = gnt_id ? req_ALU_op[5:3]  : req_ALU_op[2:0];
    sel_shamt  = gnt_id ? req_shamt[7:4]   : req_shamt[3:0];
    sel_x      = gnt_id ? req_X[1]         : req_X[0];
    sel_rot    = (sel_op == OP_ROT);
    start_iter = grant_en && sel_rot && (ROT_MULTI != 0) && (sel_shamt >= 4'd2);
    bypass     = sel_rot && (sel_shamt == 4'd0);

    case (state)
      ITER: begin
        op0    = acc;
        ALU_op = OP_ROT;
        X      = x_lat;
        if (cnt == 4'd1) begin
          state_next = RESP;
        end
      end
      IDLE, RESP: begin
        if (grant_en) begin
          req_ready[gnt_id] = 1'b1;
          op0        = sel_op0;
          op1        = sel_op1;
          ALU_op     = sel_op;
          shamt      = sel_shamt;
          X          = sel_x;
          state_next = start_iter ? ITER : RESP;
        end else if ((state == RESP) && resp_ready) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Datapath: round-robin pointer, rotate accumulator/counter and the
  // response register. The grant cycle counts as the first rotate pass,
  // so the counter starts at shamt-1 and the last pass is where cnt==1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      armed       <= 1'b0;
      last_grant  <= 1'b1;
      acc         <= 16'h0000;
      cnt         <= 4'h0;
      x_lat       <= 1'b0;
      resp_valid  <= 1'b0;
      resp_id     <= 1'b0;
      resp_result <= 16'h0000;
      resp_N      <= 1'b0;
      resp_Z      <= 1'b0;
      resp_V      <= 1'b0;
    end else begin
      armed <= 1'b1;
      if (grant_en) begin
        last_grant <= gnt_id;
        resp_id    <= gnt_id;
        if (start_iter) begin
          acc        <= result;
          cnt        <= sel_shamt - 4'd1;
          x_lat      <= sel_x;
          resp_valid <= 1'b0;
        end else if (bypass) begin
          resp_valid  <= 1'b1;
          resp_result <= sel_op0;
          resp_N      <= sel_op0[15];
          resp_Z      <= (sel_op0 == 16'h0000);
          resp_V      <= 1'b0;
        end else begin
          resp_valid  <= 1'b1;
          resp_result <= result;
          resp_N      <= N;
          resp_Z      <= Z;
          resp_V      <= V;
        end
      end else if (state == ITER) begin
        acc <= result;
        cnt <= cnt - 4'd1;
        if (cnt == 4'd1) begin
          resp_valid  <= 1'b1;
          resp_result <= result;
          resp_N      <= N;
          resp_Z      <= Z;
          resp_V      <= V;
        end
      end else if ((state == RESP) && resp_ready) begin
        resp_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: self-checking bench for alu_arbiter. Provides a small
// combinational ALU model (ROT rotates one bit per pass), a table of
// single transactions, hand-written multi-cycle sequences and a
// randomized phase checked against a transaction-level reference.

module tb_alu_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  req_valid;
  logic [1:0]  req_ready;
  logic [31:0] req_op0;
  logic [31:0] req_op1;
  logic [5:0]  req_ALU_op;
  logic [7:0]  req_shamt;
  logic [1:0]  req_X;
  logic [15:0] op0;
  logic [15:0] op1;
  logic [2:0]  ALU_op;
  logic [3:0]  shamt;
  logic        X;
  logic [15:0] result;
  logic        N;
  logic        Z;
  logic        V;
  logic        resp_valid;
  logic        resp_ready;
  logic        resp_id;
  logic [15:0] resp_result;
  logic        resp_N;
  logic        resp_Z;
  logic        resp_V;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  alu_arbiter #(.ROT_MULTI(1)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_op0(req_op0), .req_op1(req_op1), .req_ALU_op(req_ALU_op),
    .req_shamt(req_shamt), .req_X(req_X),
    .op0(op0), .op1(op1), .ALU_op(ALU_op), .shamt(shamt), .X(X),
    .result(result), .N(N), .Z(Z), .V(V),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_id(resp_id),
    .resp_result(resp_result), .resp_N(resp_N), .resp_Z(resp_Z), .resp_V(resp_V)
  );

  typedef struct {
    logic [2:0]  op;
    logic [15:0] a;
    logic [15:0] b;
    logic [3:0]  s;
    logic        x;
  } rq_t;

  typedef struct {
    logic        id;
    rq_t         rq;
    logic [15:0] res;
    logic        n;
    logic        z;
    logic        v;
    int          lat;
  } vec_t;

  // ALU behaviour; returns {N, Z, V, result}. ROT rotates rot_amt bits.
  function automatic logic [18:0] alu_eval(input logic [2:0] f, input logic [15:0] a,
                                           input logic [15:0] b, input logic [3:0] s,
                                           input logic x, input int rot_amt);
    logic [15:0] r;
    logic        v;
    r = 16'h0000;
    v = 1'b0;
    case (f)
      3'd0: r = a & b;
      3'd1: r = a | b;
      3'd2: r = a ^ b;
      3'd3: begin r = a - b; v = (a[15] != b[15]) && (r[15] != a[15]); end
      3'd4: begin r = a + b; v = (a[15] == b[15]) && (r[15] != a[15]); end
      3'd5: r = a << s;
      3'd6: r = x ? 16'($signed(a) >>> s) : (a >> s);
      default: begin
        r = a;
        for (int k = 0; k < rot_amt; k++) r = x ? {r[0], r[15:1]} : {r[14:0], r[15]};
      end
    endcase
    return {r[15], (r == 16'h0000), v, r};
  endfunction

  always_comb {N, Z, V, result} = alu_eval(ALU_op, op0, op1, shamt, X, 1);

  // Reference: a whole request in one step.
  function automatic logic [18:0] ref_resp(input rq_t r);
    if (r.op == 3'd7) begin
      if (r.s == 4'd0) return {r.a[15], (r.a == 16'h0000), 1'b0, r.a};
      return alu_eval(r.op, r.a, r.b, r.s, r.x, int'(r.s));
    end
    return alu_eval(r.op, r.a, r.b, r.s, r.x, 0);
  endfunction

  function automatic int ref_lat(input rq_t r);
    return ((r.op == 3'd7) && (r.s >= 4'd2)) ? int'(r.s) : 1;
  endfunction

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic drive_req(input int i, input rq_t r);
    if (i == 0) begin
      req_op0[15:0] = r.a; req_op1[15:0] = r.b; req_ALU_op[2:0] = r.op;
      req_shamt[3:0] = r.s; req_X[0] = r.x;
    end else begin
      req_op0[31:16] = r.a; req_op1[31:16] = r.b; req_ALU_op[5:3] = r.op;
      req_shamt[7:4] = r.s; req_X[1] = r.x;
    end
  endtask

  function automatic rq_t mk(input logic [2:0] op, input logic [15:0] a,
                             input logic [15:0] b, input logic [3:0] s, input logic x);
    rq_t r;
    r.op = op; r.a = a; r.b = b; r.s = s; r.x = x;
    return r;
  endfunction

  function automatic rq_t rnd_rq();
    rq_t r;
    r.op = ($urandom_range(0, 2) == 0) ? 3'd7 : 3'($urandom_range(0, 7));
    r.a  = 16'($urandom);
    r.b  = 16'($urandom);
    r.s  = 4'($urandom_range(0, 15));
    r.x  = 1'($urandom_range(0, 1));
    return r;
  endfunction

  task automatic drain();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      req_valid  = 2'b00;
      resp_ready = 1'b1;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    req_valid = 2'b00;
    resp_ready = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // One table transaction: grant check, then wait for the response.
  task automatic applyStimulus(input vec_t v, output int lat);
    int waits;
    @(negedge clk);
    drive_req(v.id ? 0 : 1, rnd_rq());
    drive_req(int'(v.id), v.rq);
    req_valid  = v.id ? 2'b10 : 2'b01;
    resp_ready = 1'b1;
    #1;
    check("tbl_grant", req_ready, v.id ? 2'b10 : 2'b01);
    check("tbl_alu_drive", {op0, op1, ALU_op, shamt, X},
          {v.rq.a, v.rq.b, v.rq.op, v.rq.s, v.rq.x});
    waits = 0;
    @(negedge clk);
    req_valid = 2'b00;
    #1;
    while (!resp_valid && waits < 40) begin
      waits++;
      @(negedge clk);
      #1;
    end
    lat = waits + 1;
  endtask

  task automatic checkOutput(input vec_t v, input int lat);
    check("tbl_resp_valid", resp_valid, 1'b1);
    check("tbl_latency", lat, v.lat);
    check("tbl_resp", {resp_id, resp_N, resp_Z, resp_V, resp_result},
          {v.id, v.n, v.z, v.v, v.res});
    @(negedge clk);
    #1;
    check("tbl_resp_drop", resp_valid, 1'b0);
  endtask

  vec_t vecs[12];

  // Randomized-phase reference state.
  rq_t         pend[2];
  bit          has[2];
  bit          m_last;
  int          m_busy;
  bit          m_full;
  logic [19:0] m_resp;
  logic [19:0] m_pend;

  initial begin
    int  lat;
    bit  seen;
    bit  can;
    bit  gid;
    logic [1:0] exp_ready;

    vecs[0]  = '{1'b0, mk(3'd4, 16'h0003, 16'h0004, 4'd0, 1'b0), 16'h0007, 1'b0, 1'b0, 1'b0, 1};
    vecs[1]  = '{1'b1, mk(3'd7, 16'h8001, 16'h0000, 4'd4, 1'b0), 16'h0018, 1'b0, 1'b0, 1'b0, 4};
    vecs[2]  = '{1'b0, mk(3'd7, 16'h0000, 16'h1111, 4'd0, 1'b0), 16'h0000, 1'b0, 1'b1, 1'b0, 1};
    vecs[3]  = '{1'b1, mk(3'd7, 16'h8001, 16'h0000, 4'd1, 1'b1), 16'hC000, 1'b1, 1'b0, 1'b0, 1};
    vecs[4]  = '{1'b0, mk(3'd3, 16'h0003, 16'h0004, 4'd0, 1'b0), 16'hFFFF, 1'b1, 1'b0, 1'b0, 1};
    vecs[5]  = '{1'b1, mk(3'd4, 16'h7FFF, 16'h0001, 4'd0, 1'b0), 16'h8000, 1'b1, 1'b0, 1'b1, 1};
    vecs[6]  = '{1'b0, mk(3'd7, 16'h1234, 16'h0000, 4'd8, 1'b1), 16'h3412, 1'b0, 1'b0, 1'b0, 8};
    vecs[7]  = '{1'b1, mk(3'd0, 16'hF0F0, 16'h0FF0, 4'd0, 1'b0), 16'h00F0, 1'b0, 1'b0, 1'b0, 1};
    vecs[8]  = '{1'b0, mk(3'd7, 16'h0001, 16'h0000, 4'd15, 1'b0), 16'h8000, 1'b1, 1'b0, 1'b0, 15};
    vecs[9]  = '{1'b1, mk(3'd7, 16'hABCD, 16'h0000, 4'd0, 1'b1), 16'hABCD, 1'b1, 1'b0, 1'b0, 1};
    vecs[10] = '{1'b0, mk(3'd6, 16'h8000, 16'h0000, 4'd4, 1'b1), 16'hF800, 1'b1, 1'b0, 1'b0, 1};
    vecs[11] = '{1'b1, mk(3'd5, 16'h0003, 16'h0000, 4'd2, 1'b0), 16'h000C, 1'b0, 1'b0, 1'b0, 1};

    rst_n = 1'b0;
    req_valid = 2'b00; req_op0 = '0; req_op1 = '0; req_ALU_op = '0;
    req_shamt = '0; req_X = '0; resp_ready = 1'b0;

    // Reset state with requests pending, then first-cycle lockout and tie.
    @(negedge clk);
    drive_req(0, mk(3'd4, 16'h0001, 16'h0001, 4'd0, 1'b0));
    drive_req(1, mk(3'd4, 16'h0005, 16'h0005, 4'd0, 1'b0));
    req_valid = 2'b11;
    resp_ready = 1'b1;
    #1;
    check("rst_req_ready", req_ready, 2'b00);
    check("rst_resp", {resp_valid, resp_id, resp_N, resp_Z, resp_V, resp_result}, 21'h0);
    check("rst_alu", {op0, op1, ALU_op, shamt, X}, 40'h0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("first_cycle_no_grant", req_ready, 2'b00);
    @(negedge clk);
    #1;
    check("first_tie_r0", req_ready, 2'b01);
    drain();

    // Tie held for 4 cycles alternates; responses back-to-back.
    do_reset();
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      req_valid = 2'b11;
      resp_ready = 1'b1;
      #1;
      check("rr_grant", req_ready, (k % 2 == 0) ? 2'b01 : 2'b10);
      if (k > 0) begin
        check("rr_resp", {resp_valid, resp_id, resp_result},
              (k % 2 == 1) ? {1'b1, 1'b0, 16'd2} : {1'b1, 1'b1, 16'd10});
      end
    end
    @(negedge clk);
    req_valid = 2'b00;
    #1;
    check("rr_last_resp", {resp_valid, resp_id, resp_result}, {1'b1, 1'b1, 16'd10});
    drain();

    // Multi-pass rotate on r1 blocks r0 until the response is accepted.
    @(negedge clk);
    drive_req(1, mk(3'd7, 16'h8001, 16'h0000, 4'd4, 1'b0));
    req_valid = 2'b10;
    resp_ready = 1'b1;
    #1;
    check("rot_grant", req_ready, 2'b10);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      drive_req(0, mk(3'd4, 16'h0002, 16'h0003, 4'd0, 1'b0));
      req_valid = 2'b01;
      #1;
      check("rot_iter_no_grant", req_ready, 2'b00);
    end
    @(negedge clk);
    #1;
    check("rot_resp", {resp_valid, resp_id, resp_result}, {1'b1, 1'b1, 16'h0018});
    check("rot_then_r0_grant", req_ready, 2'b01);
    @(negedge clk);
    req_valid = 2'b00;
    #1;
    check("rot_r0_resp", {resp_valid, resp_id, resp_result}, {1'b1, 1'b0, 16'd5});
    drain();

    // Back-pressure: response held, no grant while resp_ready is low.
    @(negedge clk);
    drive_req(0, mk(3'd4, 16'h0010, 16'h0020, 4'd0, 1'b0));
    req_valid = 2'b01;
    resp_ready = 1'b1;
    #1;
    check("bp_grant", req_ready, 2'b01);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      drive_req(0, mk(3'd4, 16'h0001, 16'h0002, 4'd0, 1'b0));
      resp_ready = 1'b0;
      #1;
      check("bp_no_grant", req_ready, 2'b00);
      check("bp_stable", {resp_valid, resp_id, resp_N, resp_Z, resp_V, resp_result},
            {1'b1, 1'b0, 3'b000, 16'h0030});
    end
    @(negedge clk);
    resp_ready = 1'b1;
    #1;
    check("bp_grant_on_accept", req_ready, 2'b01);
    @(negedge clk);
    req_valid = 2'b00;
    #1;
    check("bp_new_resp", {resp_valid, resp_result}, {1'b1, 16'h0003});
    drain();

    // Reset in the middle of a shamt=8 rotate.
    @(negedge clk);
    drive_req(0, mk(3'd7, 16'h1234, 16'h0000, 4'd8, 1'b1));
    req_valid = 2'b01;
    resp_ready = 1'b1;
    #1;
    check("mid_rst_grant", req_ready, 2'b01);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      req_valid = 2'b00;
    end
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_outputs", {req_ready, resp_valid, resp_result, op0, ALU_op, X}, 39'h0);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      #1;
      if (resp_valid) seen = 1'b1;
    end
    check("mid_rst_no_resp", seen, 1'b0);

    // Table of single transactions.
    for (int i = 0; i < 12; i++) begin
      applyStimulus(vecs[i], lat);
      checkOutput(vecs[i], lat);
    end

    // Randomized traffic against the transaction-level reference.
    do_reset();
    has[0] = 0; has[1] = 0;
    m_last = 1'b1; m_busy = 0; m_full = 1'b0; m_resp = '0; m_pend = '0;
    for (int c = 0; c < 1500; c++) begin
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        if (!has[i] && $urandom_range(0, 2) == 0) begin
          pend[i] = rnd_rq();
          has[i] = 1;
        end
        if (has[i]) drive_req(i, pend[i]);
      end
      req_valid  = {has[1], has[0]};
      resp_ready = ($urandom_range(0, 3) != 0);
      #1;
      can = (m_busy == 0) && (!m_full || resp_ready);
      gid = (has[0] && has[1]) ? ~m_last : has[1];
      exp_ready = (can && (has[0] || has[1])) ? (gid ? 2'b10 : 2'b01) : 2'b00;
      check("rnd_grant", req_ready, exp_ready);
      check("rnd_resp_valid", resp_valid, m_full);
      if (m_full) check("rnd_resp", {resp_id, resp_N, resp_Z, resp_V, resp_result}, m_resp);
      if (exp_ready != 2'b00) begin
        check("rnd_alu_drive", {op0, op1, ALU_op, shamt, X},
              {pend[gid].a, pend[gid].b, pend[gid].op, pend[gid].s, pend[gid].x});
      end else if (m_busy == 0) begin
        check("rnd_alu_idle", {op0, op1, ALU_op, shamt, X}, 40'h0);
      end
      if (m_full && resp_ready) m_full = 1'b0;
      if (m_busy > 0) begin
        m_busy--;
        if (m_busy == 0) begin
          m_full = 1'b1;
          m_resp = m_pend;
        end
      end
      if (exp_ready != 2'b00) begin
        m_last = gid;
        if (ref_lat(pend[gid]) == 1) begin
          m_full = 1'b1;
          m_resp = {gid, ref_resp(pend[gid])};
        end else begin
          m_busy = ref_lat(pend[gid]) - 1;
          m_pend = {gid, ref_resp(pend[gid])};
        end
        has[gid] = 0;
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
